snake_head_ctrl: RTL
====================

Name: snake_head_ctrl

Overview:
- Sits directly downstream of the PS/2 keyboard decoder and consumes its held 5-bit direction code.
- Brings that code into the system clock domain and blocks 180-degree reversals.
- Generates the game move tick and advances the snake head coordinate on a wrapping grid.
- Feeds head_x/head_y, tick and game_reset to the body/collision logic and the VGA renderer.

Parameters:
- TICK_DIV, 2500000: clk cycles per move (10 moves/s at 25 MHz); must be >= 2.
- GRID_W, 40: grid width in cells.
- GRID_H, 30: grid height in cells.
- START_X, 20: head x after reset or restart.
- START_Y, 15: head y after reset or restart.
- X_W, 6: head_x width; must satisfy 2^X_W >= GRID_W.
- Y_W, 5: head_y width; must satisfy 2^Y_W >= GRID_H.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- direction  in  5  keyboard code, asynchronous to clk and held until the next key. Codes: 00010 up, 00100 left, 01000 down, 10000 right, 11111 restart; all other values are invalid.
- enable  in  1  high = game runs; low = pause.
- head_x  out  X_W  head column.
- head_y  out  Y_W  head row (0 = top).
- cur_dir  out  5  committed direction; 00000 while idle.
- pending_dir  out  5  direction to be committed at the next tick.
- tick  out  1  one-cycle pulse on each head move.
- game_reset  out  1  one-cycle pulse on restart.
- running  out  1  high in RUN.

Behaviour:
- Async reset: head=(START_X,START_Y), cur_dir=pending_dir=00000, tick=game_reset=running=0, tick counter=0, state IDLE, synchronizer and filter registers cleared to 00000.
- CDC: two-flop synchronizer s1->s2 per bit, then s3 holds the previous s2.
- Filter: filt takes s2 when s2==s3 and s2!=filt. A filt change raises a one-cycle key_evt. Latency: pending_dir/state reflect a stable direction change within 5 clk cycles.
- key_evt with an invalid code: ignored.
- Only changes are acted on. Re-pressing the same key produces no event; this is accepted.
- States: IDLE, RUN.
- IDLE:
  - counter held at 0, no tick.
  - key_evt with an arrow code -> pending_dir=code, counter=0, state RUN, running=1.
  - key_evt with 11111 -> game_reset pulse only.
- RUN, counter:
  - Increments each cycle while enable=1 and freezes while enable=0. A counter value frozen by pause resumes where it stopped.
  - At TICK_DIV-1 with enable=1: counter=0, tick=1, cur_dir<=pending_dir, head moves one cell in pending_dir.
  - First move occurs TICK_DIV cycles after entering RUN.
- RUN, arrow key_evt:
  - Rejected if it is the exact opposite of cur_dir. Checked against cur_dir, not pending_dir, so two quick keys within one tick cannot produce a U-turn.
  - Otherwise pending_dir=code; the last accepted key before a tick wins.
- RUN, key_evt 11111:
  - Same cycle: game_reset=1, head=(START_X,START_Y), cur_dir=pending_dir=00000, counter=0, state IDLE, running=0.
  - Beats a coincident tick; no move that cycle.
- Move arithmetic, with wrap:
  - right: x = (x==GRID_W-1) ? 0 : x+1.
  - left: x = (x==0) ? GRID_W-1 : x-1.
  - down: y = (y==GRID_H-1) ? 0 : y+1.
  - up: y = (y==0) ? GRID_H-1 : y-1.
- All outputs are registered.
- Async reset mid-run returns immediately to the reset values above.

Test Plan (TICK_DIV=4, GRID_W=8, GRID_H=6, START_X=4, START_Y=3, X_W=3, Y_W=3):
- Reset, then direction=00000 for 20 cycles -> head=(4,3), cur_dir=00000, running=0, no tick, no game_reset.
- direction=10000 -> running=1 within 5 cycles. Ticks every 4 cycles thereafter; head_x 5,6,7,0 (wrap); head_y stays 3; cur_dir=10000.
- While moving right, direction=00100 -> pending_dir stays 10000. Then direction=00010 -> pending_dir=00010; next tick head_y 3->2 and cur_dir=00010.
- Moving up from y=0 -> next tick y=5. Then 01000 rejected (opposite of up); then 10000 accepted.
- direction=11111 timed so key_evt coincides with counter=3 -> game_reset pulse exactly 1 cycle, no tick, head=(4,3), cur_dir=00000, running=0.
- enable=0 for 10 cycles mid-run -> no tick and head frozen; enable=1 -> tick resumes from the held count. Assert reset mid-run -> all outputs return to reset values without waiting for a clk edge.

Source files
------------

// File: rtl/snake_head_ctrl.sv
// Snake head controller: synchronises and filters the keyboard direction, blocks U-turns, steps the head on a wrapping grid.
// A stable key change is acted on 5 clk edges after it appears; a move happens every TICK_DIV enabled cycles in RUN.
module snake_head_ctrl #(
  parameter int TICK_DIV = 2500000,
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30,
  parameter int START_X  = 20,
  parameter int START_Y  = 15,
  parameter int X_W      = 6,
  parameter int Y_W      = 5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [4:0]     direction,
  input  logic           enable,
  output logic [X_W-1:0] head_x,
  output logic [Y_W-1:0] head_y,
  output logic [4:0]     cur_dir,
  output logic [4:0]     pending_dir,
  output logic           tick,
  output logic           game_reset,
  output logic           running
);

  localparam logic [4:0] DIR_UP      = 5'b00010;
  localparam logic [4:0] DIR_LEFT    = 5'b00100;
  localparam logic [4:0] DIR_DOWN    = 5'b01000;
  localparam logic [4:0] DIR_RIGHT   = 5'b10000;
  localparam logic [4:0] DIR_RESTART = 5'b11111;

  localparam int            CW       = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [X_W-1:0] X_START = X_W'(START_X);
  localparam logic [Y_W-1:0] Y_START = Y_W'(START_Y);
  localparam logic [X_W-1:0] X_LAST  = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0] Y_LAST  = Y_W'(GRID_H - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [4:0]    s1, s2, s3, filt;
  logic          key_evt;
  logic [CW-1:0] cnt;
  logic          accept;
  logic [4:0]    eff_pend;

  function automatic logic is_arrow(input logic [4:0] d);
    return (d == DIR_UP) || (d == DIR_LEFT) || (d == DIR_DOWN) || (d == DIR_RIGHT);
  endfunction

  function automatic logic [4:0] opposite(input logic [4:0] d);
    case (d)
      DIR_UP:    return DIR_DOWN;
      DIR_DOWN:  return DIR_UP;
      DIR_LEFT:  return DIR_RIGHT;
      DIR_RIGHT: return DIR_LEFT;
      default:   return 5'b00000;
    endcase
  endfunction

  function automatic logic [X_W-1:0] step_x(input logic [X_W-1:0] x, input logic [4:0] d);
    if (d == DIR_RIGHT) return (x == X_LAST) ? '0 : x + 1'b1;
    if (d == DIR_LEFT)  return (x == '0) ? X_LAST : x - 1'b1;
    return x;
  endfunction

  function automatic logic [Y_W-1:0] step_y(input logic [Y_W-1:0] y, input logic [4:0] d);
    if (d == DIR_DOWN) return (y == Y_LAST) ? '0 : y + 1'b1;
    if (d == DIR_UP)   return (y == '0) ? Y_LAST : y - 1'b1;
    return y;
  endfunction

  // s3 lags s2 by one cycle so filt only takes a code that has been stable for two samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1      <= '0;
      s2      <= '0;
      s3      <= '0;
      filt    <= '0;
      key_evt <= 1'b0;
    end else begin
      s1      <= direction;
      s2      <= s1;
      s3      <= s2;
      key_evt <= 1'b0;
      if (s2 == s3 && s2 != filt) begin
        filt    <= s2;
        key_evt <= 1'b1;
      end
    end
  end

  // U-turn check is against the committed direction; a key landing on the tick cycle is committed by that tick
  assign accept   = key_evt && is_arrow(filt) && (filt != opposite(cur_dir));
  assign eff_pend = accept ? filt : pending_dir;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      head_x      <= X_START;
      head_y      <= Y_START;
      cur_dir     <= '0;
      pending_dir <= '0;
      tick        <= 1'b0;
      game_reset  <= 1'b0;
      running     <= 1'b0;
    end else begin
      tick       <= 1'b0;
      game_reset <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (key_evt) begin
            if (is_arrow(filt)) begin
              pending_dir <= filt;
              state       <= RUN;
              running     <= 1'b1;
            end else if (filt == DIR_RESTART) begin
              game_reset <= 1'b1;
            end
          end
        end
        RUN: begin
          if (key_evt && filt == DIR_RESTART) begin
            game_reset  <= 1'b1;
            head_x      <= X_START;
            head_y      <= Y_START;
            cur_dir     <= '0;
            pending_dir <= '0;
            cnt         <= '0;
            state       <= IDLE;
            running     <= 1'b0;
          end else begin
            pending_dir <= eff_pend;
            if (enable) begin
              if (cnt == CNT_LAST) begin
                cnt     <= '0;
                tick    <= 1'b1;
                cur_dir <= eff_pend;
                head_x  <= step_x(head_x, eff_pend);
                head_y  <= step_y(head_y, eff_pend);
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
